rv_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I datapath. It consumes the decoded instruction fields (opcode, rd, funct3, funct7) and sequences fetch, decode, execute, memory and writeback. It drives the PC, IR, register-file, ALU and memory control strobes, and handles wait-states on instruction and data memory. It also counts retired instructions and flags illegal encodings.

---
 rtl/rv_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl
//
// Control FSM for a multi-cycle RV32I datapath. It steps each instruction
// through FETCH, DECODE, EXEC, MEM and WB. It raises the control strobes that
// the PC, IR, register file, ALU and data memory need in each state, and it
// stretches FETCH and MEM for as long as the memories hold off their ready
// lines.
//
// Parameters
//   CNT_W          width of the retired-instruction counter (wraps)
//   ILLEGAL_CNT_W  width of the illegal-instruction counter (saturates)
//
// Ports
//   clk, reset     rising-edge clock; asynchronous active-high reset
//   opcode, rd,    decoded instruction fields; stable while the IR holds
//   funct3, funct7
//   imem_ready     instruction memory has data this cycle
//   dmem_ready     data memory access completes this cycle
//   branch_taken   ALU branch-condition result, meaningful in EXEC
//   imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
//   mem_read, mem_write, mem_to_reg, reg_write
//                  datapath control strobes, decoded combinationally
//   illegal        one-cycle pulse when DECODE rejects an encoding
//   state          current FSM state, for debug
//   retired        count of completed instructions
//   illegal_cnt    count of rejected instructions
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl #(
  parameter int CNT_W         = 32,
  parameter int ILLEGAL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic                     imem_ready,
  input  logic                     dmem_ready,
  input  logic                     branch_taken,
  output logic                     imem_req,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     pc_src,
  output logic                     alu_src,
  output logic [1:0]               alu_op,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     mem_to_reg,
  output logic                     reg_write,
  output logic                     illegal,
  output logic [2:0]               state,
  output logic [CNT_W-1:0]         retired,
  output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [CNT_W-1:0]         RetireInc  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ILLEGAL_CNT_W-1:0] IllegalInc = {{(ILLEGAL_CNT_W-1){1'b0}}, 1'b1};

  state_t                     r_state;
  logic [CNT_W-1:0]           r_retired;
  logic [ILLEGAL_CNT_W-1:0]   r_illegalCnt;

  state_t w_nextState;
  logic   w_retire;
  logic   w_illegalHit;
  logic   w_isRType;
  logic   w_isIAlu;
  logic   w_isLoad;
  logic   w_isStore;
  logic   w_isBranch;
  logic   w_isMemOp;
  logic   w_legal;

  // Instruction classification. Only the subset this datapath implements is
  // accepted: base R-type ALU ops plus SUB/SRA (funct7 0100000 is valid only
  // with funct3 000 or 101), any I-type ALU op, word loads/stores, and
  // BEQ/BNE. Everything else is reported as illegal in DECODE.
  assign w_isRType  = (opcode == OP_R) &&
                      ((funct7 == 7'b0000000) ||
                       ((funct7 == 7'b0100000) &&
                        ((funct3 == 3'b000) || (funct3 == 3'b101))));
  assign w_isIAlu   = (opcode == OP_IALU);
  assign w_isLoad   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
  assign w_isStore  = (opcode == OP_STORE)  && (funct3 == 3'b010);
  assign w_isBranch = (opcode == OP_BRANCH) &&
                      ((funct3 == 3'b000) || (funct3 == 3'b001));
  assign w_isMemOp  = w_isLoad || w_isStore;
  assign w_legal    = w_isRType || w_isIAlu || w_isMemOp || w_isBranch;

  // Next-state selection. w_retire marks the final cycle of an instruction
  // (branch EXEC, store MEM completion, or WB) so the counter bumps on the
  // same edge that returns the FSM to FETCH. The unused codes 5-7 fall into
  // the default arm and recover to FETCH.
  always_comb begin
    w_nextState  = FETCH;
    w_retire     = 1'b0;
    w_illegalHit = 1'b0;
    case (r_state)
      FETCH: begin
        w_nextState = imem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        if (w_legal) begin
          w_nextState = EXEC;
        end else begin
          w_illegalHit = 1'b1;
        end
      end
      EXEC: begin
        if (w_isBranch) begin
          w_retire = 1'b1;
        end else if (w_isMemOp) begin
          w_nextState = MEM;
        end else if (w_isRType || w_isIAlu) begin
          w_nextState = WB;
        end
      end
      MEM: begin
        if (w_isLoad) begin
          w_nextState = dmem_ready ? WB : MEM;
        end else if (w_isStore) begin
          if (dmem_ready) begin
            w_retire = 1'b1;
          end else begin
            w_nextState = MEM;
          end
        end
      end
      WB: begin
        w_retire = 1'b1;
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  // Datapath strobes. They are decoded combinationally so that each strobe
  // can follow the ready and taken inputs within the same cycle. All of them
  // are held low while reset is asserted. Without that, FETCH (the reset
  // state) would raise imem_req during reset.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        DECODE: begin
          illegal = !w_legal;
        end
        EXEC: begin
          if (w_isRType) begin
            alu_op = ALU_FUNCT;
          end else if (w_isIAlu) begin
            alu_op  = ALU_FUNCT;
            alu_src = 1'b1;
          end else if (w_isMemOp) begin
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
          end else if (w_isBranch) begin
            alu_op   = ALU_SUB;
            pc_src   = 1'b1;
            pc_write = branch_taken;
          end
        end
        MEM: begin
          mem_read  = w_isLoad;
          mem_write = w_isStore;
        end
        WB: begin
          reg_write  = (rd != 5'd0);
          mem_to_reg = w_isLoad;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  // State and counters. The retired count wraps naturally. The illegal count
  // stops at all-ones, so a stream of bad encodings cannot roll it back to
  // a small value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_retired    <= '0;
      r_illegalCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_retire) begin
        r_retired <= r_retired + RetireInc;
      end
      if (w_illegalHit && (r_illegalCnt != {ILLEGAL_CNT_W{1'b1}})) begin
        r_illegalCnt <= r_illegalCnt + IllegalInc;
      end
    end
  end

  assign state       = r_state;
  assign retired     = r_retired;
  assign illegal_cnt = r_illegalCnt;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_multicycle_ctrl
//
// Drives whole instructions into two copies of the controller. The second
// copy has a 2-bit illegal counter so that saturation shows up quickly.
// For each instruction, the bench predicts the cycle-by-cycle state and
// strobe pattern from the instruction class and the chosen wait-states.
// It also keeps running totals of retired and illegal instructions.
// ---------------------------------------------------------------------------
module tb_rv_multicycle_ctrl;

  typedef struct {
    logic [2:0]  st;
    logic        iRdy;
    logic        dRdy;
    logic        taken;
    logic [11:0] strb;
  } entry_t;

  localparam int CLS_ILL = 0;
  localparam int CLS_R   = 1;
  localparam int CLS_I   = 2;
  localparam int CLS_LD  = 3;
  localparam int CLS_ST  = 4;
  localparam int CLS_BR  = 5;

  // Strobe bit positions in the packed {imem_req ... illegal} vector
  localparam logic [11:0] S_IMEM  = 12'h800;
  localparam logic [11:0] S_IRW   = 12'h400;
  localparam logic [11:0] S_PCW   = 12'h200;
  localparam logic [11:0] S_PCSRC = 12'h100;
  localparam logic [11:0] S_ASRC  = 12'h080;
  localparam logic [11:0] S_OPFN  = 12'h040;
  localparam logic [11:0] S_OPSUB = 12'h020;
  localparam logic [11:0] S_MRD   = 12'h010;
  localparam logic [11:0] S_MWR   = 12'h008;
  localparam logic [11:0] S_M2R   = 12'h004;
  localparam logic [11:0] S_RW    = 12'h002;
  localparam logic [11:0] S_ILL   = 12'h001;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch_taken;

  logic        imem_req, ir_write, pc_write, pc_src, alu_src;
  logic [1:0]  alu_op;
  logic        mem_read, mem_write, mem_to_reg, reg_write, illegal;
  logic [2:0]  state;
  logic [31:0] retired;
  logic [7:0]  illegal_cnt;

  logic        imem_reqS, ir_writeS, pc_writeS, pc_srcS, alu_srcS;
  logic [1:0]  alu_opS;
  logic        mem_readS, mem_writeS, mem_to_regS, reg_writeS, illegalS;
  logic [2:0]  stateS;
  logic [31:0] retiredS;
  logic [1:0]  illegal_cntS;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned modelRetired = 0;
  int unsigned modelIll     = 0;
  int unsigned modelIllSat  = 0;
  entry_t      expQ[$];

  wire [11:0] obsStrb = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
                         mem_read, mem_write, mem_to_reg, reg_write, illegal};

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.CNT_W(32), .ILLEGAL_CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rd(rd), .funct3(funct3),
    .funct7(funct7), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .state(state),
    .retired(retired), .illegal_cnt(illegal_cnt)
  );

  rv_multicycle_ctrl #(.CNT_W(32), .ILLEGAL_CNT_W(2)) u_dutSat (
    .clk(clk), .reset(reset), .opcode(opcode), .rd(rd), .funct3(funct3),
    .funct7(funct7), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .imem_req(imem_reqS), .ir_write(ir_writeS),
    .pc_write(pc_writeS), .pc_src(pc_srcS), .alu_src(alu_srcS),
    .alu_op(alu_opS), .mem_read(mem_readS), .mem_write(mem_writeS),
    .mem_to_reg(mem_to_regS), .reg_write(reg_writeS), .illegal(illegalS),
    .state(stateS), .retired(retiredS), .illegal_cnt(illegal_cntS)
  );

  // Instruction class straight from the accepted-encoding list
  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
      return CLS_R;
    if (op == 7'h13) return CLS_I;
    if (op == 7'h03 && f3 == 3'd2) return CLS_LD;
    if (op == 7'h23 && f3 == 3'd2) return CLS_ST;
    if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) return CLS_BR;
    return CLS_ILL;
  endfunction

  function automatic entry_t mkE(input logic [2:0] st, input logic iR,
                                 input logic dR, input logic tk,
                                 input logic [11:0] s);
    entry_t e;
    e.st = st; e.iRdy = iR; e.dRdy = dR; e.taken = tk; e.strb = s;
    return e;
  endfunction

  // Expected per-cycle trace of one instruction. Inputs that should not
  // matter in a given cycle are filled with random noise.
  task automatic buildTrace(input logic [31:0] w, input int wI, input int wD,
                            input logic tk, output int cls);
    logic [11:0] wbS;
    cls = classify(w);
    expQ.delete();
    for (int k = 0; k < wI; k++)
      expQ.push_back(mkE(3'd0, 1'b0, 1'($urandom), 1'($urandom), S_IMEM));
    expQ.push_back(mkE(3'd0, 1'b1, 1'($urandom), 1'($urandom), S_IMEM | S_IRW | S_PCW));
    expQ.push_back(mkE(3'd1, 1'($urandom), 1'($urandom), 1'($urandom),
                       (cls == CLS_ILL) ? S_ILL : 12'h000));
    if (cls == CLS_ILL) return;
    case (cls)
      CLS_R:  expQ.push_back(mkE(3'd2, 1'($urandom), 1'($urandom), 1'($urandom), S_OPFN));
      CLS_I:  expQ.push_back(mkE(3'd2, 1'($urandom), 1'($urandom), 1'($urandom), S_OPFN | S_ASRC));
      CLS_BR: expQ.push_back(mkE(3'd2, 1'($urandom), 1'($urandom), tk,
                                 S_OPSUB | S_PCSRC | (tk ? S_PCW : 12'h000)));
      default: expQ.push_back(mkE(3'd2, 1'($urandom), 1'($urandom), 1'($urandom), S_ASRC));
    endcase
    if (cls == CLS_BR) return;
    if (cls == CLS_LD || cls == CLS_ST) begin
      for (int k = 0; k <= wD; k++)
        expQ.push_back(mkE(3'd3, 1'($urandom), (k == wD), 1'($urandom),
                           (cls == CLS_LD) ? S_MRD : S_MWR));
      if (cls == CLS_ST) return;
    end
    wbS = ((w[11:7] != 5'd0) ? S_RW : 12'h000) | ((cls == CLS_LD) ? S_M2R : 12'h000);
    expQ.push_back(mkE(3'd4, 1'($urandom), 1'($urandom), 1'($urandom), wbS));
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    opcode = w[6:0];
    rd     = w[11:7];
    funct3 = w[14:12];
    funct7 = w[31:25];
  endtask

  task automatic stepEntry(input int idx, input string name);
    imem_ready   = expQ[idx].iRdy;
    dmem_ready   = expQ[idx].dRdy;
    branch_taken = expQ[idx].taken;
    #2;
    checkOutput($sformatf("%s cyc%0d st/strb", name, idx),
                {17'd0, state, obsStrb}, {17'd0, expQ[idx].st, expQ[idx].strb});
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, " state"}, {29'd0, state}, 32'd0);
    checkOutput({name, " retired"}, retired, modelRetired);
    checkOutput({name, " illegal_cnt"}, {24'd0, illegal_cnt}, modelIll);
    checkOutput({name, " illegal_cnt sat"}, {30'd0, illegal_cntS}, modelIllSat);
  endtask

  // Entered and left at a falling edge
  task automatic runInstr(input logic [31:0] w, input int wI, input int wD,
                          input logic tk, input string name);
    int cls;
    buildTrace(w, wI, wD, tk, cls);
    applyStimulus(w);
    for (int i = 0; i < expQ.size(); i++) begin
      stepEntry(i, name);
      @(negedge clk);
    end
    if (cls == CLS_ILL) begin
      modelIll++;
      if (modelIllSat < 3) modelIllSat++;
    end else begin
      modelRetired++;
    end
    checkCounters(name);
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    logic [6:0]  f7opts[3];
    w = $urandom;
    f7opts[0] = 7'h00; f7opts[1] = 7'h20; f7opts[2] = 7'($urandom);
    case ($urandom_range(0, 6))
      0: begin w[6:0] = 7'h33; w[31:25] = f7opts[$urandom_range(0, 2)]; end
      1: w[6:0] = 7'h13;
      2: begin w[6:0] = 7'h03; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd2; end
      3: begin w[6:0] = 7'h23; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd2; end
      4: begin w[6:0] = 7'h63; if ($urandom_range(0, 3) != 0) w[14:12] = 3'($urandom_range(0, 1)); end
      5: w[11:7] = 5'd0;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    reset = 1'b1;
    imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
    applyStimulus(32'h00B50533);
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset strb", {20'd0, obsStrb}, 32'd0);
    checkOutput("reset strb sat", {20'd0, imem_reqS, ir_writeS, pc_writeS, pc_srcS,
                alu_srcS, alu_opS, mem_readS, mem_writeS, mem_to_regS,
                reg_writeS, illegalS}, 32'd0);
    checkCounters("reset");
    @(negedge clk);
    reset = 1'b0;

    runInstr(32'h00B50533, 0, 0, 1'b0, "ADD");
    runInstr(32'h0002A303, 0, 3, 1'b0, "LW");
    runInstr(32'h00B50463, 0, 0, 1'b1, "BEQ taken");
    runInstr(32'h00B50463, 0, 0, 1'b0, "BEQ not");
    runInstr(32'h0000007F, 0, 0, 1'b0, "ILL 7F");
    runInstr(32'h02B50533, 0, 0, 1'b0, "ILL f7=1");
    runInstr(32'h0000007F, 1, 0, 1'b0, "ILL 3");
    runInstr(32'h00028303, 0, 0, 1'b0, "ILL LB");
    runInstr(32'h40B51533, 0, 0, 1'b0, "ILL SLL f7=20");
    runInstr(32'h00000013, 0, 0, 1'b0, "ADDI x0");
    runInstr(32'h00B50533, 2, 0, 1'b0, "ADD wait");
    runInstr(32'h00B2A023, 0, 2, 1'b0, "SW");
    runInstr(32'h40B50533, 0, 0, 1'b0, "SUB");
    runInstr(32'h40B55533, 0, 0, 1'b0, "SRA");
    runInstr(32'h00B51463, 1, 0, 1'b1, "BNE");

    // Reset arriving during the first MEM cycle of a store
    begin
      int cls;
      buildTrace(32'h00B2A023, 0, 5, 1'b0, cls);
      applyStimulus(32'h00B2A023);
      for (int i = 0; i < 4; i++) begin
        stepEntry(i, "SW abort");
        if (i < 3) @(negedge clk);
      end
      reset = 1'b1;
      #1;
      checkOutput("abort strb", {20'd0, obsStrb}, 32'd0);
      modelRetired = 0; modelIll = 0; modelIllSat = 0;
      checkCounters("abort");
      imem_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      imem_ready = 1'b0;
      #2;
      checkOutput("post-reset strb", {20'd0, obsStrb}, {20'd0, S_IMEM});
      checkOutput("post-reset state", {29'd0, state}, 32'd0);
      @(negedge clk);
    end

    for (int n = 0; n < 80; n++)
      runInstr(randInstr(), $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom), $sformatf("rand%0d", n));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
